// File: rtl/button_event_queue_pkg.sv
// Shared button definitions for the press-event path.
// Button codes follow the debouncer bit order: bit0=R, bit1=G, bit2=B, bit3=Y.
package btn_pkg;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t BTN_RED    = 2'd0;
  localparam btn_code_t BTN_GREEN  = 2'd1;
  localparam btn_code_t BTN_BLUE   = 2'd2;
  localparam btn_code_t BTN_YELLOW = 2'd3;

  localparam int unsigned NUM_BTN = 4;

  // Map a one-hot button vector to its code; all-zero maps to BTN_RED.
  function automatic btn_code_t onehot_to_code(input logic [NUM_BTN-1:0] onehot);
    btn_code_t code;
    code = BTN_RED;
    unique case (onehot)
      4'b0010: code = BTN_GREEN;
      4'b0100: code = BTN_BLUE;
      4'b1000: code = BTN_YELLOW;
      default: code = BTN_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_event_queue_if.sv
// Event handshake between the press queue and the game/sequence logic.
// With BTN_EVENT_TIMESTAMP_EN defined, the head entry's timestamp is carried too.
interface button_event_queue_if #(
  parameter int unsigned TS_WIDTH = 16
);

  logic                evt_valid;
  logic                evt_ready;
  btn_pkg::btn_code_t  evt_code;
`ifdef BTN_EVENT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] evt_ts;

  modport master (output evt_valid, output evt_code, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_ts, output evt_ready);
`else
  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
`endif

endinterface

// File: rtl/button_event_queue_sync_fifo.sv
// Generic single-clock FIFO with occupancy count.
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 2,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so the output is defined after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Press-event queue behind the four button debouncers.
// Press pulses are latched in a pending register, granted lowest-index first
// into a FIFO, and presented through a valid/ready handshake. A press arriving
// on a button that is still pending (and not granted that cycle) is lost and
// sets the sticky overflow flag.
// Optional: define BTN_EVENT_TIMESTAMP_EN to store a free-running timestamp
// with every entry and present it on evt_ts.
module button_event_queue
  import btn_pkg::*;
#(
  parameter  int unsigned DEPTH    = 8,
  parameter  int unsigned TS_WIDTH = 16,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BTN-1:0]          btn_pulse,
  input  logic                        ovf_clear,
  button_event_queue_if.master        evt,
  output logic [AW:0]                 level,
  output logic                        overflow
);

`ifdef BTN_EVENT_TIMESTAMP_EN
  localparam int unsigned WIDTH = 2 + TS_WIDTH;
`else
  localparam int unsigned WIDTH = 2;
`endif

  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] drop;
  logic               do_pop;
  logic               space;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WIDTH-1:0]   fifo_din;
  logic [WIDTH-1:0]   fifo_dout;

  assign do_pop = evt.evt_valid && evt.evt_ready;
  assign space  = !fifo_full || do_pop;
  // Isolate the lowest pending bit; suppressed entirely when there is no room.
  assign grant  = space ? (pend & (~pend + 4'd1)) : '0;
  assign drop   = btn_pulse & pend & ~grant;

  // Pending presses: granted bit leaves, new pulses merge in.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~grant) | btn_pulse;
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef BTN_EVENT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_pend [NUM_BTN];
  logic [TS_WIDTH-1:0] ts_sel;

  // Free-running timestamp counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  // A merged (dropped) press keeps the timestamp of the press still queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        ts_pend[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (btn_pulse[i] && (!pend[i] || grant[i])) begin
          ts_pend[i] <= ts_cnt;
        end
      end
    end
  end

  // Select the timestamp of the granted button.
  always_comb begin
    ts_sel = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (grant[i]) begin
        ts_sel = ts_pend[i];
      end
    end
  end

  assign fifo_din   = {ts_sel, onehot_to_code(grant)};
  assign evt.evt_ts = fifo_dout[2 +: TS_WIDTH];
`else
  assign fifo_din   = onehot_to_code(grant);
`endif

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (|grant),
    .din   (fifo_din),
    .pop   (do_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = fifo_dout[1:0];

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue (DEPTH=8).
// A cycle table covers basic flow, serialisation, drops and clear priority;
// directed sequences cover full FIFO, backpressure, push+pop and reset.
module tb_button_event_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_pulse;
  logic       ovf_clear;
  logic [3:0] level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic     sb_en = 1'b0;
  int       sb_pops = 0;
  int       sb_q[$];

  button_event_queue_if #(.TS_WIDTH(16)) ifc ();

  button_event_queue #(.DEPTH(8), .TS_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .ovf_clear (ovf_clear),
    .evt       (ifc),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pulse;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic [3:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    btn_pulse = '0;
    ovf_clear = 1'b0;
    ifc.evt_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
  endtask

  // Scoreboard: compare each handshake transfer against the expected order.
  always @(negedge clk) begin
    if (sb_en && !reset && ifc.evt_valid && ifc.evt_ready) begin
      sb_pops++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", 1, 0);
      end else begin
        chk("sb_code", int'(ifc.evt_code), sb_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              pulse   rdy clr  v  code lvl ovf
    tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'd1, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[3]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2, 1'b0};
    tbl[8]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'd1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[11] = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[12] = '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0};
    tbl[14] = '{4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0};
    tbl[15] = '{4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'd5, 1'b0};
    tbl[17] = '{4'b0011, 1'b0, 1'b0, 1'b1, 2'd0, 4'd5, 1'b0};
    tbl[18] = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd0, 4'd6, 1'b1};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd7, 1'b1};

    // Reset state
    apply_reset();
    chk("rst_valid", int'(ifc.evt_valid), 0);
    chk("rst_code", int'(ifc.evt_code), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Cycle table
    for (int i = 0; i < 20; i++) begin
      btn_pulse     = tbl[i].pulse;
      ifc.evt_ready = tbl[i].ready;
      ovf_clear     = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_valid", i), int'(ifc.evt_valid), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_code", i), int'(ifc.evt_code), int'(tbl[i].exp_code));
      end
      chk($sformatf("tbl%0d_level", i), int'(level), int'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].exp_ovf));
    end
    btn_pulse = '0;
    ovf_clear = 1'b0;

    // Full FIFO, held press, drop while held, push+pop at full
    apply_reset();
    sb_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      btn_pulse = 4'b0001;
      sb_q.push_back(0);
      tick();
      btn_pulse = '0;
      tick();
      tick();
    end
    chk("full_level", int'(level), 8);
    chk("full_ovf_held", int'(overflow), 0);
    btn_pulse = 4'b0001;
    tick();
    btn_pulse = '0;
    chk("full_drop_ovf", int'(overflow), 1);
    chk("full_drop_level", int'(level), 8);
    ifc.evt_ready = 1'b1;
    tick();
    ifc.evt_ready = 1'b0;
    chk("held_written_level", int'(level), 8);
    btn_pulse = 4'b1000;
    sb_q.push_back(3);
    tick();
    btn_pulse = '0;
    chk("y_pending_level", int'(level), 8);
    ifc.evt_ready = 1'b1;
    tick();
    ifc.evt_ready = 1'b0;
    chk("pushpop_level", int'(level), 8);
    ifc.evt_ready = 1'b1;
    for (int n = 0; n < 40 && ifc.evt_valid; n++) tick();
    ifc.evt_ready = 1'b0;
    chk("drain_timeout", int'(ifc.evt_valid), 0);
    chk("drain_sb_empty", sb_q.size(), 0);
    chk("drain_level", int'(level), 0);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Backpressure stability
    btn_pulse = 4'b0010;
    sb_q.push_back(1);
    tick();
    btn_pulse = '0;
    tick();
    btn_pulse = 4'b0100;
    sb_q.push_back(2);
    tick();
    btn_pulse = '0;
    tick();
    tick();
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("bp_valid", int'(ifc.evt_valid), 1);
      chk("bp_code", int'(ifc.evt_code), 1);
    end
    begin
      int p0;
      p0 = sb_pops;
      ifc.evt_ready = 1'b1;
      repeat (10) tick();
      ifc.evt_ready = 1'b0;
      chk("bp_pop_count", sb_pops - p0, 2);
    end
    chk("bp_level", int'(level), 0);
    sb_en = 1'b0;

    // Reset mid-operation
    for (int k = 0; k < 4; k++) begin
      btn_pulse = 4'b0001;
      tick();
      btn_pulse = '0;
      tick();
    end
    btn_pulse = 4'b0011;
    tick();
    tick();
    chk("pre_rst_level", int'(level), 5);
    chk("pre_rst_ovf", int'(overflow), 1);
    reset = 1'b1;
    btn_pulse = 4'b1111;
    tick();
    reset = 1'b0;
    btn_pulse = '0;
    chk("mid_rst_valid", int'(ifc.evt_valid), 0);
    chk("mid_rst_code", int'(ifc.evt_code), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    repeat (3) tick();
    chk("post_rst_level", int'(level), 0);
    chk("post_rst_valid", int'(ifc.evt_valid), 0);

`ifdef BTN_EVENT_TIMESTAMP_EN
    // Timestamps: counter is 0 right after apply_reset returns
    apply_reset();
    repeat (100) tick();
    btn_pulse = 4'b0001;
    tick();
    btn_pulse = '0;
    repeat (149) tick();
    btn_pulse = 4'b0010;
    tick();
    btn_pulse = '0;
    tick();
    tick();
    chk("ts_first", int'(ifc.evt_ts), 100);
    ifc.evt_ready = 1'b1;
    tick();
    ifc.evt_ready = 1'b0;
    chk("ts_second", int'(ifc.evt_ts), 250);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
